// File: rtl/uart_receiver_if.sv
// Receiver-side bus bundle: 16x tick, serial line, received word and strobes.
// frame_err exists only when UART_RX_FRAME_ERR_EN is defined.
interface uart_receiver_if #(parameter int N = 8);
  logic         s_tick;
  logic         rx;
  logic [N-1:0] rx_dout;
  logic         rx_done_tick;
`ifdef UART_RX_FRAME_ERR_EN
  logic         frame_err;

  modport slave  (input s_tick, rx, output rx_dout, rx_done_tick, frame_err);
  modport master (output s_tick, rx, input rx_dout, rx_done_tick, frame_err);
`else
  modport slave  (input s_tick, rx, output rx_dout, rx_done_tick);
  modport master (output s_tick, rx, input rx_dout, rx_done_tick);
`endif
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, LSB-first 8N1-style frames, mid-bit sampling.
// Optional stop-bit error strobe enabled by defining UART_RX_FRAME_ERR_EN.
module uart_receiver #(
  parameter int n       = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int NB = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic [4:0]      r_ticks;
  logic [NB-1:0]   r_nbits;
  logic [n-1:0]    r_shreg;
  logic [n-1:0]    r_dout;
  logic            r_done;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_rxS;
`ifdef UART_RX_FRAME_ERR_EN
  logic            r_ferr;
`endif

  // Synchronizer resets to the idle-high line level so reset never fakes a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxS = r_sync2;

  // Start detection is level-based; the 7-tick wait lands the sampler mid start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ticks <= '0;
      r_nbits <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_ferr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      r_ferr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (!w_rxS) begin
            r_state <= START;
            r_ticks <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (r_ticks == 5'd7) begin
              if (!w_rxS) begin
                r_state <= DATA;
                r_ticks <= '0;
                r_nbits <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_ticks <= r_ticks + 5'd1;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (r_ticks == 5'd15) begin
              r_shreg <= {w_rxS, r_shreg[n-1:1]};
              r_ticks <= '0;
              if (r_nbits == NB'(n - 1)) begin
                r_state <= STOP;
              end else begin
                r_nbits <= r_nbits + 1'b1;
              end
            end else begin
              r_ticks <= r_ticks + 5'd1;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (r_ticks == 5'(SB_TICK - 1)) begin
              r_state <= IDLE;
              r_ticks <= '0;
              r_dout  <= r_shreg;
              r_done  <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
              r_ferr  <= ~w_rxS;
`endif
            end else begin
              r_ticks <= r_ticks + 5'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_ticks <= '0;
        end
      endcase
    end
  end

  assign bus.rx_dout      = r_dout;
  assign bus.rx_done_tick = r_done;
`ifdef UART_RX_FRAME_ERR_EN
  assign bus.frame_err    = r_ferr;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: bench-side frame serializer as the
// reference transmitter, monitor queue of received words, per-scenario tasks.
module tb_uart_receiver;

  localparam int CLK_PER_TICK = 4;
  localparam int CLK_PER_BIT  = 16 * CLK_PER_TICK;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   widePulses;
  logic prevDone;

  logic [7:0] gotData[$];
  logic       gotErr[$];
  logic [7:0] expData[$];
  logic       expErr[$];

  uart_receiver_if #(.N(8)) bus ();

  uart_receiver #(.n(8), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x-baud enable, one clk wide every CLK_PER_TICK clocks, changed on negedge.
  initial begin
    int cnt;
    cnt = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.s_tick = (cnt == CLK_PER_TICK - 1);
      cnt = (cnt + 1) % CLK_PER_TICK;
    end
  end

  // Collect every done strobe and flag any strobe wider than one clk.
  initial begin
    prevDone = 1'b0;
    widePulses = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_done_tick === 1'b1) begin
        gotData.push_back(bus.rx_dout);
`ifdef UART_RX_FRAME_ERR_EN
        gotErr.push_back(bus.frame_err);
`else
        gotErr.push_back(1'b0);
`endif
        if (prevDone === 1'b1) widePulses++;
      end
      prevDone = bus.rx_done_tick;
    end
  end

  task automatic idleClocks(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is low across its middle, then high so the line settles idle.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    bus.rx = 1'b0;
    repeat (CLK_PER_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      repeat (CLK_PER_BIT) @(negedge clk);
    end
    if (stopBit) begin
      bus.rx = 1'b1;
      repeat (CLK_PER_BIT) @(negedge clk);
    end else begin
      bus.rx = 1'b0;
      repeat (CLK_PER_BIT * 3 / 4) @(negedge clk);
      bus.rx = 1'b1;
      repeat (CLK_PER_BIT / 4) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.rx_dout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_dout got %h want 00", bus.rx_dout);
    end
    checks++;
    if (bus.rx_done_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done got %b want 0", bus.rx_done_tick);
    end
`ifdef UART_RX_FRAME_ERR_EN
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ferr got %b want 0", bus.frame_err);
    end
`endif
    reset = 1'b0;
    idleClocks(20);
    gotData.delete();
    gotErr.delete();
  endtask

  task automatic test_single_frame;
    sendFrame(8'hA5, 1'b1);
    idleClocks(16);
    checks++;
    if (gotData.size() !== 1) begin
      errors++;
      $display("[TB] FAIL single_count got %0d want 1", gotData.size());
    end else begin
      checks++;
      if (gotData[0] !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL single_data got %h want a5", gotData[0]);
      end
    end
    checks++;
    if (bus.rx_dout !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_hold got %h want a5", bus.rx_dout);
    end
    gotData.delete();
    gotErr.delete();
  endtask

  task automatic test_glitch;
    bus.rx = 1'b0;
    repeat (3 * CLK_PER_TICK) @(negedge clk);
    idleClocks(200);
    checks++;
    if (gotData.size() !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_count got %0d want 0", gotData.size());
    end
    checks++;
    if (bus.rx_dout !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL glitch_dout got %h want a5", bus.rx_dout);
    end
    sendFrame(8'h5A, 1'b1);
    idleClocks(16);
    checks++;
    if (gotData.size() !== 1 || gotData[0] !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL glitch_recover got %0d words first %h want 1 word 5a",
               gotData.size(), (gotData.size() > 0) ? gotData[0] : 8'hxx);
    end
    gotData.delete();
    gotErr.delete();
  endtask

  task automatic test_back_to_back;
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    idleClocks(16);
    checks++;
    if (gotData.size() !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d want 2", gotData.size());
    end else begin
      checks++;
      if (gotData[0] !== 8'h00 || gotData[1] !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL b2b_data got %h %h want 00 ff", gotData[0], gotData[1]);
      end
    end
    checks++;
    if (widePulses !== 0) begin
      errors++;
      $display("[TB] FAIL done_width got %0d wide pulses want 0", widePulses);
    end
    gotData.delete();
    gotErr.delete();
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h3C;
    bus.rx = 1'b0;
    repeat (CLK_PER_BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = d[i];
      repeat (CLK_PER_BIT) @(negedge clk);
    end
    bus.rx = d[4];
    repeat (CLK_PER_BIT / 2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.rx_dout !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_dout got %h want 00", bus.rx_dout);
    end
    @(negedge clk);
    reset = 1'b0;
    idleClocks(300);
    checks++;
    if (gotData.size() !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_count got %0d want 0", gotData.size());
    end
    sendFrame(8'h81, 1'b1);
    idleClocks(16);
    checks++;
    if (gotData.size() !== 1 || bus.rx_dout !== 8'h81) begin
      errors++;
      $display("[TB] FAIL midreset_next got %0d words dout %h want 1 word 81",
               gotData.size(), bus.rx_dout);
    end
    gotData.delete();
    gotErr.delete();
  endtask

  // Without the error feature a bad stop bit is ignored and the frame completes.
  task automatic test_frame_error;
    logic wantErr;
`ifdef UART_RX_FRAME_ERR_EN
    wantErr = 1'b1;
`else
    wantErr = 1'b0;
`endif
    sendFrame(8'h55, 1'b0);
    idleClocks(CLK_PER_BIT);
    sendFrame(8'h55, 1'b1);
    idleClocks(16);
    checks++;
    if (gotData.size() !== 2) begin
      errors++;
      $display("[TB] FAIL ferr_count got %0d want 2", gotData.size());
    end else begin
      checks++;
      if (gotData[0] !== 8'h55 || gotErr[0] !== wantErr) begin
        errors++;
        $display("[TB] FAIL ferr_bad got %h/%b want 55/%b", gotData[0], gotErr[0], wantErr);
      end
      checks++;
      if (gotData[1] !== 8'h55 || gotErr[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ferr_good got %h/%b want 55/0", gotData[1], gotErr[1]);
      end
    end
    gotData.delete();
    gotErr.delete();
  endtask

  // Random words, stop bits and gaps; model expects each frame's word and stop status.
  task automatic test_random_stream;
    logic [7:0] d;
    logic       stopBit;
    int         nFrames;
    nFrames = 32;
    for (int k = 0; k < nFrames; k++) begin
      d = 8'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 3) != 0);
      expData.push_back(d);
`ifdef UART_RX_FRAME_ERR_EN
      expErr.push_back(~stopBit);
`else
      expErr.push_back(1'b0);
`endif
      sendFrame(d, stopBit);
      idleClocks(stopBit ? $urandom_range(0, 20) : CLK_PER_BIT);
    end
    idleClocks(16);
    checks++;
    if (gotData.size() !== expData.size()) begin
      errors++;
      $display("[TB] FAIL rand_count got %0d want %0d", gotData.size(), expData.size());
    end else begin
      for (int k = 0; k < expData.size(); k++) begin
        checks++;
        if (gotData[k] !== expData[k] || gotErr[k] !== expErr[k]) begin
          errors++;
          $display("[TB] FAIL rand_word%0d got %h/%b want %h/%b",
                   k, gotData[k], gotErr[k], expData[k], expErr[k]);
        end
      end
    end
    checks++;
    if (widePulses !== 0) begin
      errors++;
      $display("[TB] FAIL rand_width got %0d wide pulses want 0", widePulses);
    end
    gotData.delete();
    gotErr.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.rx = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame_error();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
